ibex_csr_req_driver: RTL and testbench



---
 rtl/ibex_csr_req_driver.sv | 195 +++++++++++++++++++
 tb/tb_ibex_csr_req_driver.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_csr_req_driver.sv
`default_nettype none
// ============================================================================
// Module   : ibex_csr_req_driver
// Purpose  : Buffers CSR requests and issues one per cycle onto the
//            ibex_cs_registers access port; returns responses in order.
//            Optional statistics counters under IBEX_CSR_DRV_STATS_EN.
// Revision : 1.0
// ============================================================================
module ibex_csr_req_driver #(
    parameter int unsigned ReqDepth = 4,
    parameter int unsigned RspDepth = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [11:0] req_addr_i,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [11:0] rsp_addr_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_illegal_o,
    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    output logic        csr_op_en_o,
    input  logic [31:0] csr_rdata_i,
    input  logic        illegal_csr_insn_i,
    output logic [31:0] stat_issued_o,
    output logic [31:0] stat_illegal_o
);
    localparam int unsigned REQ_PW = $clog2(ReqDepth);
    localparam int unsigned RSP_PW = $clog2(RspDepth);
    localparam logic [REQ_PW:0] REQ_FULL = (REQ_PW+1)'(ReqDepth);
    localparam logic [RSP_PW:0] RSP_FULL = (RSP_PW+1)'(RspDepth);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    typedef struct packed {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] rdata;
        logic        illegal;
    } rsp_t;

    req_t              req_mem_q [ReqDepth];
    logic [REQ_PW-1:0] req_wptr_q, req_rptr_q;
    logic [REQ_PW:0]   req_cnt_q;
    logic              req_push, req_pop;

    rsp_t              rsp_mem_q [RspDepth];
    logic [RSP_PW-1:0] rsp_wptr_q, rsp_rptr_q;
    logic [RSP_PW:0]   rsp_cnt_q;
    logic              rsp_push, rsp_pop;
    rsp_t              rsp_head;

    logic [0:0]        state_q, state_d;
    req_t              iss_req_q;
    logic              inflight;
    logic [RSP_PW:0]   credit_use;
    logic              issue_go;

    // ---------------- request FIFO ----------------
    assign req_ready_o = (req_cnt_q != REQ_FULL);
    assign req_push    = req_valid_i && req_ready_o;
    assign req_pop     = issue_go;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_wptr_q <= '0;
            req_rptr_q <= '0;
            req_cnt_q  <= '0;
        end else begin
            if (req_push) req_wptr_q <= req_wptr_q + REQ_PW'(1);
            if (req_pop)  req_rptr_q <= req_rptr_q + REQ_PW'(1);
            case ({req_push, req_pop})
                2'b10:   req_cnt_q <= req_cnt_q + (REQ_PW+1)'(1);
                2'b01:   req_cnt_q <= req_cnt_q - (REQ_PW+1)'(1);
                default: req_cnt_q <= req_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_push) begin
            req_mem_q[req_wptr_q] <= '{addr: req_addr_i, op: req_op_i, wdata: req_wdata_i};
        end
    end

    // Credits use registered occupancy only: a same-cycle response pop frees nothing yet.
    assign inflight   = (state_q == ST_ISSUE);
    assign credit_use = rsp_cnt_q + (RSP_PW+1)'(inflight);
    assign issue_go   = (req_cnt_q != '0) && (credit_use < RSP_FULL);

    // ---------------- issue FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            iss_req_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue_go) iss_req_q <= req_mem_q[req_rptr_q];
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (issue_go) state_d = ST_ISSUE;
    end

    always_comb begin
        csr_access_o = 1'b0;
        csr_op_en_o  = 1'b0;
        csr_addr_o   = '0;
        csr_op_o     = '0;
        csr_wdata_o  = '0;
        if (state_q == ST_ISSUE) begin
            csr_access_o = 1'b1;
            csr_op_en_o  = 1'b1;
            csr_addr_o   = iss_req_q.addr;
            csr_op_o     = iss_req_q.op;
            csr_wdata_o  = iss_req_q.wdata;
        end
    end

    // ---------------- response FIFO ----------------
    assign rsp_push    = inflight;
    assign rsp_valid_o = (rsp_cnt_q != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            if (rsp_push) rsp_wptr_q <= rsp_wptr_q + RSP_PW'(1);
            if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + RSP_PW'(1);
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt_q <= rsp_cnt_q + (RSP_PW+1)'(1);
                2'b01:   rsp_cnt_q <= rsp_cnt_q - (RSP_PW+1)'(1);
                default: rsp_cnt_q <= rsp_cnt_q;
            endcase
        end
    end

    // rdata is combinational on the address in the register file, so this is the pre-write value.
    always_ff @(posedge clk_i) begin
        if (rsp_push) begin
            rsp_mem_q[rsp_wptr_q] <= '{addr: iss_req_q.addr, rdata: csr_rdata_i,
                                       illegal: illegal_csr_insn_i};
        end
    end

    assign rsp_head      = rsp_mem_q[rsp_rptr_q];
    assign rsp_addr_o    = rsp_valid_o ? rsp_head.addr    : '0;
    assign rsp_rdata_o   = rsp_valid_o ? rsp_head.rdata   : '0;
    assign rsp_illegal_o = rsp_valid_o ? rsp_head.illegal : 1'b0;

    // ---------------- statistics ----------------
`ifdef IBEX_CSR_DRV_STATS_EN
    logic [31:0] stat_issued_q, stat_illegal_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_issued_q  <= '0;
            stat_illegal_q <= '0;
        end else begin
            if (inflight && (stat_issued_q != '1)) begin
                stat_issued_q <= stat_issued_q + 32'd1;
            end
            if (rsp_push && illegal_csr_insn_i && (stat_illegal_q != '1)) begin
                stat_illegal_q <= stat_illegal_q + 32'd1;
            end
        end
    end

    assign stat_issued_o  = stat_issued_q;
    assign stat_illegal_o = stat_illegal_q;
`else
    assign stat_issued_o  = '0;
    assign stat_illegal_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_csr_req_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_csr_req_driver
// Purpose  : Self-checking bench for ibex_csr_req_driver with a small CSR
//            register-file stand-in and a queue-based transaction model.
// Revision : 1.0
// ============================================================================
module tb_ibex_csr_req_driver;
    localparam int REQ_DEPTH = 4;
    localparam int RSP_DEPTH = 4;
    localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_SET = 2'd2, OP_CLEAR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o;
    logic [11:0] req_addr_i;
    logic [1:0]  req_op_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [11:0] rsp_addr_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_illegal_o;
    logic        csr_access_o, csr_op_en_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata_i;
    logic        illegal_csr_insn_i;
    logic [31:0] stat_issued_o, stat_illegal_o;

    ibex_csr_req_driver #(.ReqDepth(REQ_DEPTH), .RspDepth(RSP_DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_addr_o(rsp_addr_o), .rsp_rdata_o(rsp_rdata_o), .rsp_illegal_o(rsp_illegal_o),
        .csr_access_o(csr_access_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_op_o(csr_op_o), .csr_op_en_o(csr_op_en_o),
        .csr_rdata_i(csr_rdata_i), .illegal_csr_insn_i(illegal_csr_insn_i),
        .stat_issued_o(stat_issued_o), .stat_illegal_o(stat_illegal_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic csr_legal(input logic [11:0] a);
        return (a == 12'h340) || (a == 12'h300) || (a == 12'h341) || (a == 12'h305);
    endfunction

    function automatic logic [31:0] apply_op(input logic [1:0] op, input logic [31:0] old,
                                             input logic [31:0] wd);
        case (op)
            OP_WRITE: return wd;
            OP_SET:   return old | wd;
            OP_CLEAR: return old & ~wd;
            default:  return old;
        endcase
    endfunction

    function automatic logic [31:0] exp_stat(input logic [31:0] v);
`ifdef IBEX_CSR_DRV_STATS_EN
        return v;
`else
        return v & 32'h0;
`endif
    endfunction

    // ---------------- register-file stand-in ----------------
    logic        clear_env;
    logic [31:0] env_csr [4096];
    logic        env_pend;
    logic [11:0] env_addr;
    logic [1:0]  env_op;
    logic [31:0] env_wd;

    assign csr_rdata_i        = env_csr[csr_addr_o];
    assign illegal_csr_insn_i = csr_access_o && !csr_legal(csr_addr_o);

    always @(negedge clk) begin
        env_pend <= csr_access_o;
        env_addr <= csr_addr_o;
        env_op   <= csr_op_o;
        env_wd   <= csr_wdata_o;
    end

    always @(posedge clk) begin
        if (clear_env) begin
            for (int i = 0; i < 4096; i++) env_csr[i] <= '0;
        end else if (env_pend && rst_ni && csr_legal(env_addr)) begin
            env_csr[env_addr] <= apply_op(env_op, env_csr[env_addr], env_wd);
        end
    end

    // ---------------- transaction model + compare ----------------
    typedef struct { logic [11:0] addr; logic [1:0] op; logic [31:0] wd; } req_s;
    typedef struct { logic [11:0] addr; logic [31:0] rd; logic ill; } rsp_s;

    req_s        iss_q[$];
    rsp_s        exp_q[$];
    logic [31:0] model_csr [4096];
    logic [31:0] m_issued, m_illegal;
    int          n_access = 0;
    int          n_rsp_pop = 0;

    always @(negedge clk) begin : p_cmp
        req_s cur;
        rsp_s r;
        int   fifo_cnt;
        logic acc;
        if (clear_env) begin
            for (int i = 0; i < 4096; i++) model_csr[i] = '0;
        end
        if (!rst_ni) begin
            iss_q.delete();
            exp_q.delete();
            m_issued  = '0;
            m_illegal = '0;
            check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
            check("rst_flags", {60'd0, rsp_valid_o, csr_access_o, csr_op_en_o, rsp_illegal_o}, 64'd0);
            check("rst_stats", {stat_issued_o, stat_illegal_o}, 64'd0);
            check("rst_csr_bus", {18'd0, csr_addr_o, csr_op_o, csr_wdata_o}, 64'd0);
            check("rst_rsp_bus", {20'd0, rsp_addr_o, rsp_rdata_o}, 64'd0);
        end else begin
            acc = csr_access_o;
            check("stat_issued", {32'd0, stat_issued_o}, {32'd0, exp_stat(m_issued)});
            check("stat_illegal", {32'd0, stat_illegal_o}, {32'd0, exp_stat(m_illegal)});
            if (acc) begin
                n_access++;
                m_issued = m_issued + 32'd1;
                check("csr_op_en", {63'd0, csr_op_en_o}, 64'd1);
                if (iss_q.size() == 0) begin
                    check("issue_spurious", {63'd0, acc}, 64'd0);
                end else begin
                    cur = iss_q.pop_front();
                    check("csr_addr", {52'd0, csr_addr_o}, {52'd0, cur.addr});
                    check("csr_op", {62'd0, csr_op_o}, {62'd0, cur.op});
                    check("csr_wdata", {32'd0, csr_wdata_o}, {32'd0, cur.wd});
                    if (!csr_legal(cur.addr)) m_illegal = m_illegal + 32'd1;
                end
            end else begin
                check("csr_idle_bus", {17'd0, csr_op_en_o, csr_addr_o, csr_op_o, csr_wdata_o}, 64'd0);
            end
            fifo_cnt = exp_q.size() - iss_q.size() - (acc ? 1 : 0);
            check("req_ready", {63'd0, req_ready_o}, {63'd0, (iss_q.size() < REQ_DEPTH)});
            check("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, (fifo_cnt > 0)});
            if (rsp_valid_o && exp_q.size() > 0) begin
                r = exp_q[0];
                check("rsp_addr", {52'd0, rsp_addr_o}, {52'd0, r.addr});
                check("rsp_rdata", {32'd0, rsp_rdata_o}, {32'd0, r.rd});
                check("rsp_illegal", {63'd0, rsp_illegal_o}, {63'd0, r.ill});
                if (rsp_ready_i) begin
                    void'(exp_q.pop_front());
                    n_rsp_pop++;
                end
            end
            if (req_valid_i && req_ready_o) begin
                r.addr = req_addr_i;
                r.rd   = model_csr[req_addr_i];
                r.ill  = !csr_legal(req_addr_i);
                exp_q.push_back(r);
                if (csr_legal(req_addr_i)) begin
                    model_csr[req_addr_i] = apply_op(req_op_i, model_csr[req_addr_i], req_wdata_i);
                end
                cur.addr = req_addr_i;
                cur.op   = req_op_i;
                cur.wd   = req_wdata_i;
                iss_q.push_back(cur);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        int guard = 0;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_op_i    = op;
        req_wdata_i = wd;
        @(negedge clk);
        while (!req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready_o) check("push_timeout", {63'd0, req_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic expect_rsp(input string nm, input logic [11:0] a, input logic [31:0] d,
                              input logic ill);
        int guard = 0;
        @(negedge clk);
        while (!rsp_valid_o && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check({nm, "_valid"}, {63'd0, rsp_valid_o}, 64'd1);
        check({nm, "_addr"}, {52'd0, rsp_addr_o}, {52'd0, a});
        check({nm, "_rdata"}, {32'd0, rsp_rdata_o}, {32'd0, d});
        check({nm, "_illegal"}, {63'd0, rsp_illegal_o}, {63'd0, ill});
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int run, max_run, win_acc, base_acc, base_pop, stale;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        clear_env   = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_op_i    = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_ni    = 1'b1;
        clear_env = 1'b0;
        @(posedge clk);
        #1;

        // Write then read mscratch, checking cycle-exact latency.
        push_req(12'h340, OP_WRITE, 32'hA5A5_0001);
        expect_rsp("t1_wr", 12'h340, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        push_req(12'h340, OP_READ, 32'h0);
        @(negedge clk);
        check("lat0_access", {63'd0, csr_access_o}, 64'd0);
        check("lat0_valid", {63'd0, rsp_valid_o}, 64'd0);
        @(negedge clk);
        check("lat1_access", {63'd0, csr_access_o}, 64'd1);
        check("lat1_valid", {63'd0, rsp_valid_o}, 64'd0);
        @(negedge clk);
        check("lat2_valid", {63'd0, rsp_valid_o}, 64'd1);
        check("lat2_rdata", {32'd0, rsp_rdata_o}, 64'hA5A5_0001);
        check("lat2_illegal", {63'd0, rsp_illegal_o}, 64'd0);
        check("lat2_access", {63'd0, csr_access_o}, 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back WRITE/SET/CLEAR/READ.
        rsp_ready_i = 1'b0;
        run = 0; max_run = 0; win_acc = 0;
        fork
            begin
                push_req(12'h340, OP_WRITE, 32'hFFFF_0000);
                push_req(12'h340, OP_SET,   32'h0000_00FF);
                push_req(12'h340, OP_CLEAR, 32'h0F00_0000);
                push_req(12'h340, OP_READ,  32'h0);
            end
            begin
                repeat (8) begin
                    @(negedge clk);
                    if (csr_access_o) begin
                        run++;
                        win_acc++;
                        if (run > max_run) max_run = run;
                    end else begin
                        run = 0;
                    end
                end
            end
        join
        check("b2b_max_run", 64'(max_run), 64'd4);
        check("b2b_total", 64'(win_acc), 64'd4);
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        expect_rsp("b2b0", 12'h340, 32'hA5A5_0001, 1'b0);
        expect_rsp("b2b1", 12'h340, 32'hFFFF_0000, 1'b0);
        expect_rsp("b2b2", 12'h340, 32'hFFFF_00FF, 1'b0);
        expect_rsp("b2b3", 12'h340, 32'hF0FF_00FF, 1'b0);

        // Unimplemented CSR.
        apply_reset();
        push_req(12'h7FF, OP_READ, 32'h0);
        expect_rsp("ill", 12'h7FF, 32'h0, 1'b1);
`ifdef IBEX_CSR_DRV_STATS_EN
        check("ill_stat_illegal", {32'd0, stat_illegal_o}, 64'd1);
        check("ill_stat_issued", {32'd0, stat_issued_o}, 64'd1);
`else
        check("ill_stat_illegal", {32'd0, stat_illegal_o}, 64'd0);
        check("ill_stat_issued", {32'd0, stat_issued_o}, 64'd0);
`endif
        @(posedge clk);
        #1;

        // Credit stall: six requests, no response consumer.
        apply_reset();
        rsp_ready_i = 1'b0;
        base_acc = n_access;
        push_req(12'h300, OP_WRITE, 32'h1);
        push_req(12'h300, OP_READ,  32'h0);
        push_req(12'h341, OP_WRITE, 32'h2);
        push_req(12'h341, OP_READ,  32'h0);
        push_req(12'h300, OP_SET,   32'h4);
        push_req(12'h300, OP_READ,  32'h0);
        repeat (6) @(negedge clk);
        check("stall_issues", 64'(n_access - base_acc), 64'd4);
        check("stall_access", {63'd0, csr_access_o}, 64'd0);
        check("stall_ready_partial", {63'd0, req_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        push_req(12'h305, OP_WRITE, 32'h8);
        push_req(12'h305, OP_READ,  32'h0);
        @(negedge clk);
        check("stall_ready_full", {63'd0, req_ready_o}, 64'd0);
        check("stall_issues_still", 64'(n_access - base_acc), 64'd4);
        @(posedge clk);
        #1;
        base_pop = n_rsp_pop;
        rsp_ready_i = 1'b1;
        expect_rsp("drain0", 12'h300, 32'h0, 1'b0);
        expect_rsp("drain1", 12'h300, 32'h1, 1'b0);
        expect_rsp("drain2", 12'h341, 32'h0, 1'b0);
        expect_rsp("drain3", 12'h341, 32'h2, 1'b0);
        expect_rsp("drain4", 12'h300, 32'h1, 1'b0);
        expect_rsp("drain5", 12'h300, 32'h5, 1'b0);
        expect_rsp("drain6", 12'h305, 32'h0, 1'b0);
        expect_rsp("drain7", 12'h305, 32'h8, 1'b0);
        @(negedge clk);
        check("drain_count", 64'(n_rsp_pop - base_pop), 64'd8);
        check("drain_empty", {63'd0, rsp_valid_o}, 64'd0);
        @(posedge clk);
        #1;

        // Reset during an ISSUE cycle.
        rsp_ready_i = 1'b0;
        push_req(12'h340, OP_READ, 32'h0);
        push_req(12'h340, OP_READ, 32'h0);
        push_req(12'h340, OP_READ, 32'h0);
        begin
            int guard = 0;
            @(negedge clk);
            while (!csr_access_o && guard < 10) begin
                @(negedge clk);
                guard++;
            end
        end
        check("mid_pre_access", {63'd0, csr_access_o}, 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        check("mid_async_access", {63'd0, csr_access_o}, 64'd0);
        check("mid_async_valid", {63'd0, rsp_valid_o}, 64'd0);
        check("mid_async_addr", {52'd0, csr_addr_o}, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_ni = 1'b1;
        #1;
        check("mid_release_ready", {63'd0, req_ready_o}, 64'd1);
        rsp_ready_i = 1'b1;
        base_acc = n_access;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid_o) stale++;
        end
        check("mid_no_stale_rsp", 64'(stale), 64'd0);
        check("mid_no_reissue", 64'(n_access - base_acc), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
